multicycle_control_fsm: RTL and testbench

- Multicycle sequencer for the MIPS datapath: replaces single-cycle opcode decode with a per-instruction state machine.
- Sequences fetch, decode, execute, memory and writeback over shared ALU and unified memory; waits on a memory ready handshake.
- Counts retired instructions.
- Control encodings match the single-cycle unit:
  - ALU op is {1'b1, opcode} for I/branch/memory instructions and 0 for R-type.
  - Memory size codes are 01 byte, 10 half, 11 word.

---
 rtl/multicycle_control_fsm.sv | 150 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS sequencer; ports clk/reset, opcode, mem_ready in; datapath controls, state, illegal_op, instr_done, instr_count out
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic [1:0]       mem_read,
  output logic [1:0]       mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [6:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             link,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, WB_R = 4'd3,
    EXEC_I = 4'd4, WB_I = 4'd5, MEM_ADDR = 4'd6, MEM_RD = 4'd7,
    WB_MEM = 4'd8, MEM_WR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
  } st_t;
  st_t              r_state, w_next, w_dec;
  logic [5:0]       r_op;
  logic [CNT_W-1:0] r_count;
  assign state       = r_state;
  assign instr_count = r_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= opcode;
      if (instr_done) r_count <= r_count + CNT_W'(1);
    end
  end
  always_comb begin
    w_dec = FETCH;
    case (opcode)
      6'd0:                                 w_dec = EXEC_R;
      6'd8, 6'd10, 6'd12, 6'd13, 6'd14:     w_dec = EXEC_I;
      6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43: w_dec = MEM_ADDR;
      6'd1, 6'd4, 6'd5:                     w_dec = BRANCH;
      6'd2, 6'd3:                           w_dec = JUMP;
      default:                              w_dec = FETCH;
    endcase
  end
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = mem_ready ? DECODE : FETCH;
      DECODE:   w_next = w_dec;
      EXEC_R:   w_next = WB_R;
      EXEC_I:   w_next = WB_I;
      MEM_ADDR: w_next = (r_op < 6'd40) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
      default:  w_next = FETCH;
    endcase
  end
  // Outputs are forced low while reset is held so an aborted access issues nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 2'b00;
    mem_write     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 7'd0;
    pc_source     = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    link          = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          mem_read  = 2'b11;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = (w_dec == FETCH);
        end
        EXEC_R: alu_src_a = 1'b1;
        WB_R: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_I, MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = {1'b1, r_op};
        end
        WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = (r_op == 6'd32) ? 2'b01 : (r_op == 6'd33) ? 2'b10 : 2'b11;
        end
        WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          i_or_d     = 1'b1;
          mem_write  = (r_op == 6'd40) ? 2'b01 : (r_op == 6'd41) ? 2'b10 : 2'b11;
          instr_done = mem_ready;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = {1'b1, r_op};
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          reg_write  = (r_op == 6'd3);
          link       = (r_op == 6'd3);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed scoreboard bench for the multicycle sequencer
module tb_multicycle_control_fsm;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic [1:0] mem_read;
    logic [1:0] mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [6:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;
  typedef struct {
    string       tag;
    logic [3:0]  st;
    ctrl_t       c;
    logic [31:0] cnt;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, alu_src_a;
  logic        reg_dst, mem_to_reg, reg_write, link, illegal_op, instr_done;
  logic [1:0]  mem_read, mem_write, alu_src_b, pc_source;
  logic [6:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;
  ctrl_t       obs;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .link(link), .state(state),
    .illegal_op(illegal_op), .instr_done(instr_done), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  assign obs = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg,
                reg_write, link, illegal_op, instr_done};
  function automatic ctrl_t x_fetch(logic mr);
    ctrl_t c = '0;
    c.mem_read = 2'b11; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr;
    return c;
  endfunction
  function automatic ctrl_t x_decode(logic ill);
    ctrl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal_op = ill;
    return c;
  endfunction
  function automatic ctrl_t x_exec_r();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t x_imm(logic [6:0] op);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op;
    return c;
  endfunction
  function automatic ctrl_t x_wb(logic rd, logic m2r);
    ctrl_t c = '0;
    c.reg_dst = rd; c.mem_to_reg = m2r; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t x_mem_rd(logic [1:0] sz);
    ctrl_t c = '0;
    c.i_or_d = 1'b1; c.mem_read = sz;
    return c;
  endfunction
  function automatic ctrl_t x_mem_wr(logic [1:0] sz, logic mr);
    ctrl_t c = '0;
    c.i_or_d = 1'b1; c.mem_write = sz; c.instr_done = mr;
    return c;
  endfunction
  function automatic ctrl_t x_branch(logic [6:0] op);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = op; c.pc_write_cond = 1'b1;
    c.pc_source = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t x_jump(logic lnk);
    ctrl_t c = '0;
    c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = lnk; c.link = lnk;
    c.instr_done = 1'b1;
    return c;
  endfunction
  task automatic check();
    exp_t e = q.pop_front();
    total++;
    assert (state === e.st) else begin
      bad++;
      $error("FAIL %s state got=%0d want=%0d", e.tag, state, e.st);
    end
    total++;
    assert (obs === e.c) else begin
      bad++;
      $error("FAIL %s ctrl got=%b want=%b", e.tag, obs, e.c);
    end
    total++;
    assert (instr_count === e.cnt) else begin
      bad++;
      $error("FAIL %s count got=%0d want=%0d", e.tag, instr_count, e.cnt);
    end
  endtask
  task automatic step(string tag, logic [5:0] op, logic mr, logic rst,
                      logic [3:0] st, ctrl_t c, logic [31:0] cnt);
    exp_t e;
    @(negedge clk);
    reset = rst; opcode = op; mem_ready = mr;
    e.tag = tag; e.st = st; e.c = c; e.cnt = cnt;
    q.push_back(e);
    #1 check();
  endtask
  initial begin
    exp_t e;
    step("rst",      6'd0,  1, 1, 4'd0,  '0,                   0);
    step("add_f",    6'd0,  1, 0, 4'd0,  x_fetch(1),           0);
    step("add_d",    6'd0,  0, 0, 4'd1,  x_decode(0),          0);
    step("add_x",    6'h3f, 0, 0, 4'd2,  x_exec_r(),           0);
    step("add_wb",   6'd0,  1, 0, 4'd3,  x_wb(1, 0),           0);
    step("lw_f",     6'd35, 1, 0, 4'd0,  x_fetch(1),           1);
    step("lw_d",     6'd35, 1, 0, 4'd1,  x_decode(0),          1);
    step("lw_a",     6'd0,  1, 0, 4'd6,  x_imm(7'b1100011),    1);
    step("lw_r0",    6'd0,  0, 0, 4'd7,  x_mem_rd(2'b11),      1);
    step("lw_r1",    6'd0,  0, 0, 4'd7,  x_mem_rd(2'b11),      1);
    step("lw_r2",    6'd0,  0, 0, 4'd7,  x_mem_rd(2'b11),      1);
    step("lw_r3",    6'd0,  1, 0, 4'd7,  x_mem_rd(2'b11),      1);
    step("lw_wb",    6'd0,  0, 0, 4'd8,  x_wb(0, 1),           1);
    step("sb_fw",    6'd0,  0, 0, 4'd0,  x_fetch(0),           2);
    step("sb_f",     6'd40, 1, 0, 4'd0,  x_fetch(1),           2);
    step("sb_d",     6'd40, 0, 0, 4'd1,  x_decode(0),          2);
    step("sb_a",     6'd0,  0, 0, 4'd6,  x_imm(7'b1101000),    2);
    step("sb_w0",    6'd0,  0, 0, 4'd9,  x_mem_wr(2'b01, 0),   2);
    step("sb_w1",    6'd0,  1, 0, 4'd9,  x_mem_wr(2'b01, 1),   2);
    step("beq_f",    6'd4,  1, 0, 4'd0,  x_fetch(1),           3);
    step("beq_d",    6'd4,  0, 0, 4'd1,  x_decode(0),          3);
    step("beq_b",    6'd0,  1, 0, 4'd10, x_branch(7'b1000100), 3);
    step("jal_f",    6'd3,  1, 0, 4'd0,  x_fetch(1),           4);
    step("jal_d",    6'd3,  0, 0, 4'd1,  x_decode(0),          4);
    step("jal_j",    6'd0,  0, 0, 4'd11, x_jump(1),            4);
    step("addi_f",   6'd8,  1, 0, 4'd0,  x_fetch(1),           5);
    step("addi_d",   6'd8,  0, 0, 4'd1,  x_decode(0),          5);
    step("addi_x",   6'd0,  0, 0, 4'd4,  x_imm(7'b1001000),    5);
    step("addi_wb",  6'd0,  0, 0, 4'd5,  x_wb(0, 0),           5);
    step("ill_f",    6'd9,  1, 0, 4'd0,  x_fetch(1),           6);
    step("ill_d",    6'd9,  0, 0, 4'd1,  x_decode(1),          6);
    step("ill_back", 6'd0,  0, 0, 4'd0,  x_fetch(0),           6);
    step("j_f",      6'd2,  1, 0, 4'd0,  x_fetch(1),           6);
    step("j_d",      6'd2,  0, 0, 4'd1,  x_decode(0),          6);
    step("j_j",      6'd0,  0, 0, 4'd11, x_jump(0),            6);
    step("lh_f",     6'd33, 1, 0, 4'd0,  x_fetch(1),           7);
    step("lh_d",     6'd33, 0, 0, 4'd1,  x_decode(0),          7);
    step("lh_a",     6'd0,  0, 0, 4'd6,  x_imm(7'b1100001),    7);
    step("lh_r",     6'd0,  0, 0, 4'd7,  x_mem_rd(2'b10),      7);
    #2 reset = 1'b1;
    e.tag = "arst"; e.st = 4'd0; e.c = '0; e.cnt = 0;
    q.push_back(e);
    #1 check();
    step("arst_hold", 6'd0, 1, 1, 4'd0,  '0,                   0);
    step("post_f0",   6'd0, 0, 0, 4'd0,  x_fetch(0),           0);
    step("post_f1",   6'd0, 1, 0, 4'd0,  x_fetch(1),           0);
    step("post_d",    6'd0, 0, 0, 4'd1,  x_decode(0),          0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
